// File: rtl/eth_f_pkt_gen_pkg.sv
// Shared types, constants and helpers for the 25G packet-client generator.
package eth_f_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        IPG  = 2'd2,
        DONE = 2'd3
    } pkt_gen_state_e;

    // Plain-vector aliases of the state encoding for logic [1:0] state registers
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_IPG  = IPG;
    localparam logic [1:0] ST_DONE = DONE;

    localparam int MIN_PKT_LEN    = 64;
    localparam int MAX_PKT_LEN    = 9600;
    localparam int BYTES_PER_BEAT = 8;

    // Unused byte lanes on the last beat; only the byte offset within a beat matters
    function automatic logic [2:0] calc_empty(input logic [2:0] len);
        logic [3:0] r;
        r = 4'(BYTES_PER_BEAT) - {1'b0, len};
        return r[2:0];
    endfunction

endpackage

// File: rtl/eth_f_packet_client_pkt_gen_25g_if.sv
// Avalon-ST TX bus between the packet generator and its sink.
interface eth_f_packet_client_pkt_gen_25g_if #(
    parameter int WIDTH       = 64,
    parameter int EMPTY_WIDTH = 3
);
    logic                   tx_valid;
    logic                   tx_sop;
    logic                   tx_eop;
    logic [WIDTH-1:0]       tx_data;
    logic [EMPTY_WIDTH-1:0] tx_empty;
    logic                   tx_ready;

    modport master (
        output tx_valid, tx_sop, tx_eop, tx_data, tx_empty,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, tx_sop, tx_eop, tx_data, tx_empty,
        output tx_ready
    );
endinterface

// File: rtl/eth_f_pkt_gen_len_seq.sv
// Packet length sequencer: clamps the configured range, walks fixed or
// incrementing lengths and derives beat count and eop empty for the next packet.
module eth_f_pkt_gen_len_seq
    import eth_f_pkt_gen_pkg::*;
#(
    parameter int LEN_WIDTH   = 14,
    parameter int EMPTY_WIDTH = 3,
    parameter int BEAT_W      = LEN_WIDTH - 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_len_mode,
    input  logic [LEN_WIDTH-1:0]   i_len_min,
    input  logic [LEN_WIDTH-1:0]   i_len_max,
    input  logic                   i_restart,
    input  logic                   i_next_pkt,
    output logic [BEAT_W-1:0]      o_beats,
    output logic [EMPTY_WIDTH-1:0] o_empty
);

    logic [LEN_WIDTH-1:0] cur_len;
    logic [LEN_WIDTH-1:0] min_c;
    logic [LEN_WIDTH-1:0] max_raw;
    logic [LEN_WIDTH-1:0] max_c;
    logic [LEN_WIDTH-1:0] eff_len;
    logic [LEN_WIDTH:0]   len_plus;

    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        if (len < LEN_WIDTH'(MIN_PKT_LEN))
            return LEN_WIDTH'(MIN_PKT_LEN);
        else if (len > LEN_WIDTH'(MAX_PKT_LEN))
            return LEN_WIDTH'(MAX_PKT_LEN);
        else
            return len;
    endfunction

    // Legal range and the length of the packet about to start; a stale register
    // that falls outside a reconfigured range snaps back to the minimum
    always_comb begin
        min_c    = clamp_len(i_len_min);
        max_raw  = clamp_len(i_len_max);
        max_c    = (max_raw < min_c) ? min_c : max_raw;
        eff_len  = min_c;
        if (i_len_mode && cur_len >= min_c && cur_len <= max_c)
            eff_len = cur_len;
        len_plus = {1'b0, eff_len} + (LEN_WIDTH+1)'(BYTES_PER_BEAT - 1);
        o_beats  = BEAT_W'(len_plus >> 3);
        o_empty  = EMPTY_WIDTH'(calc_empty(eff_len[2:0]));
    end

    // Length register: restarts at the minimum for each run, steps once per packet
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cur_len <= clamp_len(i_len_min);
        end else if (i_restart) begin
            cur_len <= min_c;
        end else if (i_next_pkt) begin
            if (!i_len_mode || eff_len >= max_c)
                cur_len <= min_c;
            else
                cur_len <= eff_len + LEN_WIDTH'(1);
        end
    end

endmodule

// File: rtl/eth_f_packet_client_pkt_gen_25g.sv
// 25G packet-client generator: emits incrementing-word packets on Avalon-ST,
// one-shot or continuous, with fixed/incrementing lengths and an inter-packet gap.
module eth_f_packet_client_pkt_gen_25g
    import eth_f_pkt_gen_pkg::*;
#(
    parameter int               WIDTH       = 64,
    parameter int               EMPTY_WIDTH = 3,
    parameter logic [WIDTH-1:0] DATA_SEED   = 64'h11223344_10203040,
    parameter int               LEN_WIDTH   = 14
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cfg_pkt_gen_tx_en,
    input  logic                  i_cfg_pkt_gen_cont_mode,
    input  logic [31:0]           i_cfg_pkt_num,
    input  logic                  i_cfg_len_mode,
    input  logic [LEN_WIDTH-1:0]  i_cfg_pkt_len_min,
    input  logic [LEN_WIDTH-1:0]  i_cfg_pkt_len_max,
    input  logic [7:0]            i_cfg_ipg_cycles,
    eth_f_packet_client_pkt_gen_25g_if.master tx,
    output logic [31:0]           o_pkt_sent_cnt,
    output logic                  o_gen_done,
    output logic                  o_busy
);

    localparam int BEAT_W = LEN_WIDTH - 2;

    logic [1:0]             state;
    logic [WIDTH-1:0]       data_reg;
    logic [BEAT_W-1:0]      beat_idx;
    logic [BEAT_W-1:0]      pkt_beats;
    logic [EMPTY_WIDTH-1:0] pkt_empty;
    logic [BEAT_W-1:0]      seq_beats;
    logic [EMPTY_WIDTH-1:0] seq_empty;
    logic [7:0]             ipg_cnt;
    logic [31:0]            sent_cnt;
    logic [31:0]            sent_cnt_inc;
    logic                   in_send;
    logic                   is_sop;
    logic                   is_eop;
    logic                   beat_acc;
    logic                   sop_acc;
    logic                   eop_acc;
    logic                   run_start;
    logic [WIDTH-1:0]       eop_mask;

    eth_f_pkt_gen_len_seq #(
        .LEN_WIDTH   (LEN_WIDTH),
        .EMPTY_WIDTH (EMPTY_WIDTH),
        .BEAT_W      (BEAT_W)
    ) u_len_seq (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_len_mode (i_cfg_len_mode),
        .i_len_min  (i_cfg_pkt_len_min),
        .i_len_max  (i_cfg_pkt_len_max),
        .i_restart  (run_start),
        .i_next_pkt (sop_acc),
        .o_beats    (seq_beats),
        .o_empty    (seq_empty)
    );

    // Beat framing and handshake decode; packets are at least 8 beats so sop and eop never share a beat
    always_comb begin
        in_send      = (state == ST_SEND);
        is_sop       = in_send && (beat_idx == '0);
        is_eop       = in_send && (beat_idx != '0) && (beat_idx == pkt_beats - BEAT_W'(1));
        beat_acc     = in_send && tx.tx_ready;
        sop_acc      = beat_acc && is_sop;
        eop_acc      = beat_acc && is_eop;
        run_start    = (state == ST_IDLE) && i_cfg_pkt_gen_tx_en;
        sent_cnt_inc = (sent_cnt == 32'hFFFF_FFFF) ? sent_cnt : sent_cnt + 32'd1;
        eop_mask     = {WIDTH{1'b1}} << {pkt_empty, 3'b000};
    end

    // Outputs are decoded from registers only, so they stay frozen while the sink stalls
    assign tx.tx_valid     = in_send;
    assign tx.tx_sop       = is_sop;
    assign tx.tx_eop       = is_eop;
    assign tx.tx_data      = !in_send ? '0 : (is_eop ? (data_reg & eop_mask) : data_reg);
    assign tx.tx_empty     = is_eop ? pkt_empty : '0;
    assign o_pkt_sent_cnt  = sent_cnt;
    assign o_gen_done      = (state == ST_DONE);
    assign o_busy          = (state != ST_IDLE);

    // Datapath: payload counter runs across packets, packet shape is captured at sop
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_reg  <= DATA_SEED;
            beat_idx  <= '0;
            pkt_beats <= '0;
            pkt_empty <= '0;
        end else begin
            if (beat_acc) begin
                data_reg <= data_reg + WIDTH'(1);
                beat_idx <= is_eop ? '0 : beat_idx + BEAT_W'(1);
            end
            if (sop_acc) begin
                pkt_beats <= seq_beats;
                pkt_empty <= seq_empty;
            end
        end
    end

    // Run control: packet counting, gap timing and one-shot completion
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            ipg_cnt  <= '0;
            sent_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cfg_pkt_gen_tx_en) begin
                        sent_cnt <= '0;
                        if (!i_cfg_pkt_gen_cont_mode && i_cfg_pkt_num == 32'd0)
                            state <= ST_DONE;
                        else
                            state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (eop_acc) begin
                        sent_cnt <= sent_cnt_inc;
                        if (!i_cfg_pkt_gen_cont_mode && sent_cnt_inc == i_cfg_pkt_num) begin
                            state <= ST_DONE;
                        end else if (!i_cfg_pkt_gen_tx_en) begin
                            state <= ST_IDLE;
                        end else if (i_cfg_ipg_cycles != 8'd0) begin
                            state   <= ST_IPG;
                            ipg_cnt <= i_cfg_ipg_cycles;
                        end
                    end
                end
                ST_IPG: begin
                    if (ipg_cnt <= 8'd1)
                        state <= i_cfg_pkt_gen_tx_en ? ST_SEND : ST_IDLE;
                    else
                        ipg_cnt <= ipg_cnt - 8'd1;
                end
                default: begin
                    if (!i_cfg_pkt_gen_tx_en)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
